lsb_rs: RTL
===========

// Module: lsb_rs
// PURPOSE
// - Reservation station for loads and stores, directly upstream of the load/store buffer.
// - Holds decoded memory ops until their base operand is known (and, for stores, the data operand).
// - Snoops both CDBs (ALU and load/store buffer results) to wake waiting operands.
// - Issues one op per cycle to the load/store buffer: op, ROB tag, address = rs1 + imm, wdata = rs2.
// PARAMETERS
// - RS_SIZE   4  number of entries
// - RS_WIDTH  2  log2(RS_SIZE)
// - ROB_WIDTH 4  ROB tag width
// PORTS
// - clk_in          in   1          clock; all state updates on the rising edge
// - rst_in          in   1          synchronous, active-high reset
// - rdy_in          in   1          global enable; when 0, all state and outputs hold
// - clear           in   1          branch mispredict flush
// - from_decoder    in   1          dispatch valid
// - dec_op          in   4          LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=5 SH=6 SW=7
// - dec_tag         in   ROB_WIDTH  ROB tag of the op
// - dec_rs1_rdy     in   1          rs1 value valid; else wait on dec_rs1_tag
// - dec_rs1_val     in   32         rs1 value
// - dec_rs1_tag     in   ROB_WIDTH  rs1 producer tag
// - dec_rs2_rdy     in   1          rs2 value valid (don't-care for loads)
// - dec_rs2_val     in   32         rs2 value
// - dec_rs2_tag     in   ROB_WIDTH  rs2 producer tag
// - dec_imm         in   32         sign-extended offset
// - alu_cdb         in   1          ALU result broadcast valid
// - alu_cdb_tag     in   ROB_WIDTH  ALU result tag
// - alu_cdb_data    in   32         ALU result data
// - lsb_cdb         in   1          load result broadcast valid
// - lsb_cdb_tag     in   ROB_WIDTH  load result tag
// - lsb_cdb_data    in   32         load result data
// - to_lsb          out  1          issue valid, one-cycle pulse
// - to_lsb_op       out  4          issued op
// - to_lsb_tag      out  ROB_WIDTH  issued ROB tag
// - to_lsb_wdata    out  32         store data (rs2 value)
// - to_lsb_address  out  32         effective address
// - rs_bsy          out  1          1 = decoder may dispatch
// BEHAVIOUR
// - Reset: all entries invalid; to_lsb=0; other to_lsb_* = 0; rs_bsy=1.
// - Entry fields: valid, op, tag, q1, v1, r1, q2, v2, r2, imm.
// - Loads set r2=1 at dispatch.
// - Dispatch:
//   - Target is the lowest-index entry invalid before this edge.
//   - Dispatch with no free entry is dropped.
//   - A dispatched operand whose tag matches alu_cdb or lsb_cdb in the same cycle captures that data and is ready.
// - Wakeup: every valid waiting operand whose q matches a valid CDB tag takes the data and sets r.
// - Issue:
//   - Select one valid entry with r1 & r2, using the pre-edge state.
//   - At the edge: to_lsb<=1; address<=v1+imm (mod 2^32); wdata<=v2; op/tag copied; entry invalidated.
//   - No ready entry: to_lsb<=0; other outputs hold.
// - Latency:
//   - Op dispatched ready at edge N issues at edge N+1 at the earliest.
//   - Op woken by a CDB at edge N issues at edge N+1 at the earliest.
// - Dispatch and issue in the same cycle: both occur; the freed slot is reusable from the next cycle.
// - rs_bsy:
//   - Registered; 1 iff the post-edge free-entry count is >= 2.
//   - The second free entry covers the decoder's one-cycle response.
// - clear (priority over all other inputs):
//   - All entries invalid; to_lsb<=0; rs_bsy<=1.
//   - Dispatch, wakeup and issue in that cycle are discarded.
// - rdy_in=0: no state change; CDB broadcasts in that cycle are lost (the CDB sources also hold).
// CONFIGURATION
// - LSB_RS_AGE_ORDER_EN defined:
//   - Each entry keeps a RS_WIDTH-bit age, set at dispatch.
//   - Ages are renormalised on issue.
//   - Issue selects the oldest ready entry, i.e. program order among ready ops.
// - LSB_RS_AGE_ORDER_EN undefined: issue selects the lowest-index ready entry; no age storage.
// TESTING
// - Ready LW dispatch:
//   - Stimulus: LW tag=3, rs1=0x1000, imm=-4.
//   - Response: next cycle to_lsb=1, addr=0x0FFC, op=4, tag=3.
// - SW wakeup:
//   - Stimulus: SW tag=5 waiting rs1 on tag 2; then alu_cdb tag=2, data=0x200; rs2=0xAB.
//   - Response: next cycle to_lsb=1, addr=0x200+imm, wdata=0xAB.
// - Same-cycle forward:
//   - Stimulus: dispatch LB waiting on tag 7 while lsb_cdb tag=7, data=0x40, imm=1.
//   - Response: issue next cycle with addr=0x41.
// - Fill:
//   - Stimulus: dispatch 3 non-ready ops.
//   - Response: rs_bsy=0 after the 3rd.
//   - Stimulus: wake one.
//   - Response: it issues; rs_bsy returns to 1.
// - Flush:
//   - Stimulus: 2 pending ops; clear asserted with alu_cdb waking both.
//   - Response: to_lsb stays 0 thereafter; rs_bsy=1.
// - Order (AGE_ORDER_EN):
//   - Stimulus: entry1 older than entry0, both woken the same cycle.
//   - Response: entry1 issues first, entry0 the following cycle.

Source files
------------

// File: rtl/lsb_rs.sv
// lsb_rs: load/store reservation station feeding the load/store buffer.
// Optional LSB_RS_AGE_ORDER_EN: issue the oldest ready entry instead of the lowest-index one.
module lsb_rs #(
  parameter int RS_SIZE   = 4,
  parameter int RS_WIDTH  = 2,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 from_decoder,
  input  logic [3:0]           dec_op,
  input  logic [ROB_WIDTH-1:0] dec_tag,
  input  logic                 dec_rs1_rdy,
  input  logic [31:0]          dec_rs1_val,
  input  logic [ROB_WIDTH-1:0] dec_rs1_tag,
  input  logic                 dec_rs2_rdy,
  input  logic [31:0]          dec_rs2_val,
  input  logic [ROB_WIDTH-1:0] dec_rs2_tag,
  input  logic [31:0]          dec_imm,
  input  logic                 alu_cdb,
  input  logic [ROB_WIDTH-1:0] alu_cdb_tag,
  input  logic [31:0]          alu_cdb_data,
  input  logic                 lsb_cdb,
  input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
  input  logic [31:0]          lsb_cdb_data,
  output logic                 to_lsb,
  output logic [3:0]           to_lsb_op,
  output logic [ROB_WIDTH-1:0] to_lsb_tag,
  output logic [31:0]          to_lsb_wdata,
  output logic [31:0]          to_lsb_address,
  output logic                 rs_bsy
);
  localparam int CW = RS_WIDTH + 1;

  typedef struct packed {
    logic                 vld;
    logic [3:0]           op;
    logic [ROB_WIDTH-1:0] tag;
    logic [ROB_WIDTH-1:0] q1;
    logic [31:0]          v1;
    logic                 r1;
    logic [ROB_WIDTH-1:0] q2;
    logic [31:0]          v2;
    logic                 r2;
    logic [31:0]          imm;
  } ent_t;

  ent_t                ent_q [RS_SIZE];
  ent_t                ent_d [RS_SIZE];
  ent_t                new_ent;
  logic                iss_vld, dsp_free, dsp_vld;
  logic [RS_WIDTH-1:0] iss_idx, dsp_idx;
  logic [CW-1:0]       free_d;

`ifdef LSB_RS_AGE_ORDER_EN
  // Ages of valid entries stay compact (0 = oldest); stale ages of free slots are ignored.
  logic [RS_WIDTH-1:0] age_q [RS_SIZE];
  logic [RS_WIDTH-1:0] age_d [RS_SIZE];
  logic [CW-1:0]       vld_cnt;
`endif

  // Issue pick from pre-edge state only, so a wakeup or dispatch costs one cycle.
  always_comb begin
    iss_vld = 1'b0;
    iss_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef LSB_RS_AGE_ORDER_EN
      if (ent_q[i].vld && ent_q[i].r1 && ent_q[i].r2 &&
          (!iss_vld || age_q[i] < age_q[iss_idx])) begin
`else
      if (ent_q[i].vld && ent_q[i].r1 && ent_q[i].r2 && !iss_vld) begin
`endif
        iss_vld = 1'b1;
        iss_idx = RS_WIDTH'(i);
      end
    end
  end

  always_comb begin
    dsp_free = 1'b0;
    dsp_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].vld) begin
        dsp_free = 1'b1;
        dsp_idx  = RS_WIDTH'(i);
      end
    end
    dsp_vld = from_decoder & dsp_free;
  end

  // Incoming op, with same-cycle CDB forwarding on both operands.
  always_comb begin
    new_ent     = '0;
    new_ent.vld = 1'b1;
    new_ent.op  = dec_op;
    new_ent.tag = dec_tag;
    new_ent.q1  = dec_rs1_tag;
    new_ent.v1  = dec_rs1_val;
    new_ent.r1  = dec_rs1_rdy;
    new_ent.q2  = dec_rs2_tag;
    new_ent.v2  = dec_rs2_val;
    new_ent.r2  = dec_rs2_rdy;
    new_ent.imm = dec_imm;
    if (!dec_rs1_rdy && alu_cdb && dec_rs1_tag == alu_cdb_tag) begin
      new_ent.v1 = alu_cdb_data; new_ent.r1 = 1'b1;
    end
    if (!dec_rs1_rdy && lsb_cdb && dec_rs1_tag == lsb_cdb_tag) begin
      new_ent.v1 = lsb_cdb_data; new_ent.r1 = 1'b1;
    end
    if (!dec_rs2_rdy && alu_cdb && dec_rs2_tag == alu_cdb_tag) begin
      new_ent.v2 = alu_cdb_data; new_ent.r2 = 1'b1;
    end
    if (!dec_rs2_rdy && lsb_cdb && dec_rs2_tag == lsb_cdb_tag) begin
      new_ent.v2 = lsb_cdb_data; new_ent.r2 = 1'b1;
    end
    if (dec_op < 4'd5) new_ent.r2 = 1'b1;
  end

  always_comb begin
    free_d = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (!ent_q[i].r1 && alu_cdb && ent_q[i].q1 == alu_cdb_tag) begin
        ent_d[i].v1 = alu_cdb_data; ent_d[i].r1 = 1'b1;
      end
      if (!ent_q[i].r1 && lsb_cdb && ent_q[i].q1 == lsb_cdb_tag) begin
        ent_d[i].v1 = lsb_cdb_data; ent_d[i].r1 = 1'b1;
      end
      if (!ent_q[i].r2 && alu_cdb && ent_q[i].q2 == alu_cdb_tag) begin
        ent_d[i].v2 = alu_cdb_data; ent_d[i].r2 = 1'b1;
      end
      if (!ent_q[i].r2 && lsb_cdb && ent_q[i].q2 == lsb_cdb_tag) begin
        ent_d[i].v2 = lsb_cdb_data; ent_d[i].r2 = 1'b1;
      end
      if (iss_vld && iss_idx == RS_WIDTH'(i)) ent_d[i].vld = 1'b0;
      if (dsp_vld && dsp_idx == RS_WIDTH'(i)) ent_d[i] = new_ent;
      free_d = free_d + {{RS_WIDTH{1'b0}}, ~ent_d[i].vld};
    end
  end

`ifdef LSB_RS_AGE_ORDER_EN
  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) vld_cnt = vld_cnt + {{RS_WIDTH{1'b0}}, ent_q[i].vld};
    for (int i = 0; i < RS_SIZE; i++) begin
      age_d[i] = age_q[i];
      if (iss_vld && age_q[i] > age_q[iss_idx]) age_d[i] = age_q[i] - RS_WIDTH'(1);
      if (dsp_vld && dsp_idx == RS_WIDTH'(i))
        age_d[i] = RS_WIDTH'(vld_cnt - {{RS_WIDTH{1'b0}}, iss_vld});
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
    end else if (rdy_in && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= age_d[i];
    end
  end
`endif

  // clear outranks rdy_in so a flush is never lost to a stall.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      to_lsb         <= 1'b0;
      to_lsb_op      <= '0;
      to_lsb_tag     <= '0;
      to_lsb_wdata   <= '0;
      to_lsb_address <= '0;
      rs_bsy         <= 1'b1;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].vld <= 1'b0;
      to_lsb <= 1'b0;
      rs_bsy <= 1'b1;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      to_lsb <= iss_vld;
      if (iss_vld) begin
        to_lsb_op      <= ent_q[iss_idx].op;
        to_lsb_tag     <= ent_q[iss_idx].tag;
        to_lsb_wdata   <= ent_q[iss_idx].v2;
        to_lsb_address <= ent_q[iss_idx].v1 + ent_q[iss_idx].imm;
      end
      rs_bsy <= (free_d >= CW'(2));
    end
  end
endmodule
